// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// This is a stateful stall unit for the 5-stage MIPS pipeline. It sits beside
// the D stage. Each architectural register has a small countdown that holds
// the number of cycles left before its pending result can be forwarded. The
// unit compares the countdowns for the D instruction's sources against that
// instruction's Tuse values. A separate occupancy counter models the
// multiply/divide unit, so MDU stalls need no external busy input. The stall
// output freezes PC/IF-ID and inserts a bubble into ID-EX.
//
// Optional feature: define HAZARD_SCOREBOARD_PERF_EN to build a 32-bit counter
// of stall cycles. If the macro is not defined, perf_stall_cnt is tied to 0
// and no counter flops are built.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   d_valid         D holds a real instruction (0 = bubble)
//   d_rs, d_rt      source register addresses of the D instruction
//   d_rs_tuse       cycles until rs is consumed (0 = consumed in D)
//   d_rt_tuse       cycles until rt is consumed
//   d_wr_en         D instruction writes the register file
//   d_wr_addr       destination register
//   d_tnew          Tnew of the D instruction once it is in E
//   d_md_start      D instruction starts an MDU operation
//   d_md_div        with d_md_start: 1 = divide, 0 = multiply
//   d_md_use        D instruction touches the MDU (mult/div/mt/mf)
//   stall           freeze D, bubble E
//   rs_stall        rs-caused component of stall
//   rt_stall        rt-caused component of stall
//   md_stall        MDU-caused component of stall
//   md_busy         MDU occupancy counter nonzero
//   perf_stall_cnt  stall-cycle counter (0 unless the macro is defined)

module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_rs_tuse,
  input  logic [TW-1:0] d_rt_tuse,
  input  logic          d_wr_en,
  input  logic [AW-1:0] d_wr_addr,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_md_use,
  output logic          stall,
  output logic          rs_stall,
  output logic          rt_stall,
  output logic          md_stall,
  output logic          md_busy,
  output logic [31:0]   perf_stall_cnt
);

  localparam int MD_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  // One extra count covers the E cycle in which the start is seen.
  localparam int MW     = $clog2(MD_MAX + 2);

  localparam logic [MW-1:0] MUL_LOAD = MW'(MUL_CYC + 1);
  localparam logic [MW-1:0] DIV_LOAD = MW'(DIV_CYC + 1);

  function automatic logic [TW-1:0] sat_dec_cnt(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [MW-1:0] sat_dec_md(input logic [MW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // Entry 0 is never loaded, so it stays 0 and synthesis removes it.
  logic [TW-1:0] cnt [NREG];
  logic [MW-1:0] md_cnt;

  logic          issue;
  logic          wr_hit;
  logic [TW-1:0] rs_cnt;
  logic [TW-1:0] rt_cnt;

  assign issue  = d_valid & ~stall;
  assign wr_hit = issue & d_wr_en & (d_wr_addr != '0);

  // Look up the source counts. An address of 0, or an address that does not
  // match any tracked entry, reads as 0.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (d_rs == AW'(r)) rs_cnt = cnt[r];
      if (d_rt == AW'(r)) rt_cnt = cnt[r];
    end
  end

  assign rs_stall = d_valid & (d_rs != '0) & (rs_cnt > d_rs_tuse);
  assign rt_stall = d_valid & (d_rt != '0) & (rt_cnt > d_rt_tuse);
  assign md_busy  = (md_cnt != '0);
  assign md_stall = d_valid & d_md_use & md_busy;
  assign stall    = rs_stall | rt_stall | md_stall;

  // The scoreboard decrements every cycle because E/M/W never stall. A new
  // issue to a register replaces its count, so the latest writer wins (WAW).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit && (d_wr_addr == AW'(r))) cnt[r] <= d_tnew;
        else                                 cnt[r] <= sat_dec_cnt(cnt[r]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (issue && d_md_start) begin
      md_cnt <= d_md_div ? DIV_LOAD : MUL_LOAD;
    end else begin
      md_cnt <= sat_dec_md(md_cnt);
    end
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] perf_cnt;

  // Wraps naturally from 0xFFFFFFFF to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     perf_cnt <= '0;
    else if (stall) perf_cnt <= perf_cnt + 32'd1;
  end

  assign perf_stall_cnt = perf_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_rs_tuse;
  logic [1:0]  d_rt_tuse;
  logic        d_wr_en;
  logic [4:0]  d_wr_addr;
  logic [1:0]  d_tnew;
  logic        d_md_start;
  logic        d_md_div;
  logic        d_md_use;
  logic        stall;
  logic        rs_stall;
  logic        rt_stall;
  logic        md_stall;
  logic        md_busy;
  logic [31:0] perf_stall_cnt;

  hazard_scoreboard #(
    .NREG(32), .AW(5), .TW(2), .MUL_CYC(5), .DIV_CYC(10)
  ) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .rs_stall(rs_stall), .rt_stall(rt_stall),
    .md_stall(md_stall), .md_busy(md_busy), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] rs;
    logic [1:0] rs_tu;
    logic [4:0] rt;
    logic [1:0] rt_tu;
    logic       we;
    logic [4:0] wa;
    logic [1:0] tn;
    logic       ms;
    logic       mdv;
    logic       mu;
    logic [4:0] ex;   // {stall, rs_stall, rt_stall, md_stall, md_busy}
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  int a_end;

  function automatic vec_t mk(bit vld, int rs, int rs_tu, int rt, int rt_tu,
                              bit we, int wa, int tn, bit ms, bit mdv, bit mu,
                              logic [4:0] ex);
    vec_t v;
    v.vld = vld;          v.rs = 5'(rs);    v.rs_tu = 2'(rs_tu);
    v.rt = 5'(rt);        v.rt_tu = 2'(rt_tu);
    v.we = we;            v.wa = 5'(wa);    v.tn = 2'(tn);
    v.ms = ms;            v.mdv = mdv;      v.mu = mu;
    v.ex = ex;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    d_valid = v.vld;  d_rs = v.rs;  d_rs_tuse = v.rs_tu;
    d_rt = v.rt;      d_rt_tuse = v.rt_tu;
    d_wr_en = v.we;   d_wr_addr = v.wa;  d_tnew = v.tn;
    d_md_start = v.ms; d_md_div = v.mdv; d_md_use = v.mu;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] ex);
    chk({tag, "_stall"},    32'(stall),    32'(ex[4]));
    chk({tag, "_rs_stall"}, 32'(rs_stall), 32'(ex[3]));
    chk({tag, "_rt_stall"}, 32'(rt_stall), 32'(ex[2]));
    chk({tag, "_md_stall"}, 32'(md_stall), 32'(ex[1]));
    chk({tag, "_md_busy"},  32'(md_busy),  32'(ex[0]));
  endtask

  initial begin
    // Load-use followed by a divide with mflo waiting behind it.
    tbl.push_back(mk(1, 1,1, 0,3, 1, 8,2, 0,0,0, 5'b00000)); // lw $8
    tbl.push_back(mk(1, 8,1, 9,1, 1,10,1, 0,0,0, 5'b11000)); // add rs=$8
    tbl.push_back(mk(1, 8,1, 9,1, 1,10,1, 0,0,0, 5'b00000)); // add proceeds
    tbl.push_back(mk(1, 8,0, 0,0, 0, 0,0, 0,0,0, 5'b00000)); // cnt[8]=0
    tbl.push_back(mk(1, 1,1, 2,1, 0, 0,0, 1,1,1, 5'b00000)); // div
    for (int k = 0; k < 11; k++)
      tbl.push_back(mk(1, 0,3, 0,3, 1,12,1, 0,0,1, 5'b10011)); // mflo waits
    tbl.push_back(mk(1, 0,3, 0,3, 1,12,1, 0,0,1, 5'b00000)); // mflo issues
    a_end = tbl.size() - 1;
    // Branch after ALU result, and the $0 variant.
    tbl.push_back(mk(1, 1,1, 2,1, 1, 3,1, 0,0,0, 5'b00000)); // addu $3
    tbl.push_back(mk(1, 4,0, 3,0, 0, 0,0, 0,0,0, 5'b10100)); // beq rt=$3
    tbl.push_back(mk(1, 4,0, 3,0, 0, 0,0, 0,0,0, 5'b00000));
    tbl.push_back(mk(1, 1,1, 2,1, 1, 0,1, 0,0,0, 5'b00000)); // addu $0
    tbl.push_back(mk(1, 0,0, 0,0, 0, 0,0, 0,0,0, 5'b00000)); // beq $0,$0
    // Multiply. A non-MDU instruction still proceeds while the MDU is busy.
    tbl.push_back(mk(1, 1,1, 2,1, 0, 0,0, 1,0,1, 5'b00000)); // mult
    tbl.push_back(mk(1, 1,1, 2,1, 1, 7,1, 0,0,0, 5'b00001)); // addu, busy
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 0,3, 0,3, 1,12,1, 0,0,1, 5'b10011)); // mflo waits
    tbl.push_back(mk(1, 0,3, 0,3, 1,12,1, 0,0,1, 5'b00000));
    // WAW: the latest issue to a register sets its count.
    tbl.push_back(mk(1, 1,1, 0,3, 1, 5,2, 0,0,0, 5'b00000)); // lw $5
    tbl.push_back(mk(1, 1,1, 2,1, 1, 5,1, 0,0,0, 5'b00000)); // addu $5
    tbl.push_back(mk(1, 1,1, 5,2, 0, 0,0, 0,0,0, 5'b00000)); // sw rt=$5
    tbl.push_back(mk(1, 1,1, 2,1, 1, 5,1, 0,0,0, 5'b00000)); // addu $5
    tbl.push_back(mk(1, 1,1, 0,3, 1, 5,2, 0,0,0, 5'b00000)); // lw $5
    tbl.push_back(mk(1, 5,0, 0,0, 0, 0,0, 0,0,0, 5'b11000)); // beq rs=$5
    tbl.push_back(mk(1, 5,0, 0,0, 0, 0,0, 0,0,0, 5'b11000));
    tbl.push_back(mk(1, 5,0, 0,0, 0, 0,0, 0,0,0, 5'b00000));

    // Reset state
    reset = 1'b0;
    apply(mk(0, 0,0, 0,0, 0, 0,0, 0,0,0, 5'b00000));
    #2;
    chk_outs("reset", 5'b00000);
    chk("reset_perf", perf_stall_cnt, 32'd0);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      chk_outs($sformatf("v%0d", i), tbl[i].ex);
`ifndef HAZARD_SCOREBOARD_PERF_EN
      chk($sformatf("v%0d_perf", i), perf_stall_cnt, 32'd0);
`else
      if (i == a_end) chk("perf_after_loaduse_div", perf_stall_cnt, 32'd12);
`endif
      @(posedge clk);
      #1;
    end
`ifdef HAZARD_SCOREBOARD_PERF_EN
    chk("perf_after_table", perf_stall_cnt, 32'd20);
`endif

    // Assert async reset in the middle of a divide, with md_cnt=6 and cnt[8]=2.
    apply(mk(1, 1,1, 2,1, 0, 0,0, 1,1,1, 5'b00000));         // div
    #1 chk_outs("rdiv_issue", 5'b00000);
    @(posedge clk); #1;                                      // md_cnt=11
    apply(mk(0, 0,0, 0,0, 0, 0,0, 0,0,0, 5'b00000));
    repeat (4) @(posedge clk);                               // md_cnt=7
    #1;
    apply(mk(1, 1,1, 0,3, 1, 8,2, 0,0,0, 5'b00000));         // lw $8
    #1 chk_outs("rlw_issue", 5'b00001);
    @(posedge clk); #1;                                      // md_cnt=6, cnt[8]=2
    apply(mk(1, 8,0, 0,3, 0, 0,0, 0,0,1, 5'b00000));         // mflo-like, rs=$8
    #1 chk_outs("pre_reset", 5'b11011);
    reset = 1'b0;
    #1 chk_outs("in_reset", 5'b00000);
    chk("in_reset_perf", perf_stall_cnt, 32'd0);
    reset = 1'b1;
    #1 chk_outs("post_release", 5'b00000);
    @(posedge clk); #1;
    chk_outs("post_release_edge", 5'b00000);
    chk("post_release_perf", perf_stall_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
